button_pio_in: RTL and testbench
================================

Name: button_pio_in

Overview:
- Avalon-MM slave input PIO, the read-side counterpart of the LED output PIOs. Samples external pushbutton/switch pins for the Nios II.
- Per bit, the block synchronises, debounces, captures selected edges and raises a maskable level interrupt.
- Sits on the system interconnect beside the LED PIOs and uses the same 2-bit address, chipselect and write_n register access style.

Parameters:
- WIDTH, 8, number of input pins and register width.
- DEBOUNCE_CYCLES, 16, consecutive clk cycles a synchronised level must hold before it is accepted. Legal range is 1 to 65535.
- IN_RESET_VALUE, 8'hFF, reset value of the synchroniser and stable registers. The default matches idle active-low buttons.

Ports:
- clk, input, 1, the single clock.
- reset, input, 1, asynchronous active-high reset.
- address, input, 2, register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, WIDTH, write data.
- in_port, input, WIDTH, asynchronous external pins.
- readdata, output, WIDTH, read data, combinational from registers.
- irq, output, 1, level interrupt.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - sync1, sync2, stable and stable_d = IN_RESET_VALUE.
  - Debounce counters = 0.
  - irqmask = 0, edgecapture = 0, edgesel = 0.
  - irq = 0. readdata reflects the reset register values.
- Reset asserted mid-debounce or mid-capture discards all progress immediately. No edge is captured for the reset transition itself.
- Synchroniser: per bit, two flops in series (sync1 <= in_port, sync2 <= sync1).
- Debounce, per bit:
  - If sync2 == stable, the counter is cleared to 0.
  - Otherwise the counter increments. On the edge where the counter would reach DEBOUNCE_CYCLES, stable <= sync2 and the counter clears.
  - Any return of sync2 to stable before that edge clears the counter.
  - The counter saturates; it never wraps.
- Latency: a pin change present before edge 0 appears in stable, and in data reads, after edge DEBOUNCE_CYCLES+1.
- Edge detect: stable_d <= stable every cycle.
  - rise = stable & ~stable_d.
  - fall = ~stable & stable_d.
  - detected = edgesel ? rise : fall, per bit.
- Edgecapture:
  - Bit sets on the edge after detected is high, i.e. one cycle after the stable update.
  - Bit is sticky until cleared.
- Register map (access only when chipselect = 1):
  - Address 0, data: read-only, returns stable. Writes are ignored.
  - Address 1, irqmask: read/write.
  - Address 2, edgecapture: read returns the capture bits. A write is write-1-to-clear per bit.
  - Address 3, edgesel: read/write. 1 = capture rising edges, 0 = capture falling edges.
- Access rules:
  - A write occurs when chipselect & ~write_n.
  - Reads have zero wait states and no read side effects.
  - readdata is 0 when chipselect = 0.
- Simultaneous events:
  - A clear and a new edge on the same bit in the same cycle: set wins, so the bit stays 1.
  - A clear of bit i does not affect other bits.
  - A write to edgesel takes effect for detection on the next cycle. It never retroactively sets capture bits.
- irq = |(edgecapture & irqmask), taken from registered values with no extra pipeline.
  - irq deasserts the cycle after the clearing write or after the mask write.
- Bits are fully independent. All widths follow WIDTH. The counter width is clog2(DEBOUNCE_CYCLES+1).

Test Plan (bench uses WIDTH=8, DEBOUNCE_CYCLES=4, IN_RESET_VALUE=8'hFF):
1. Reset: hold in_port=8'hFF, pulse reset mid-cycle, then read addresses 0 to 3 -> readdata 8'hFF, 0, 0, 0; irq=0 throughout, including the reset release.
2. Latency: drive in_port[0] 1->0 before edge 0 and hold it -> data reads 8'hFE first after edge 5. edgecapture reads 8'h01 after edge 6. irq stays 0 because the mask is 0.
3. Bounce: in_port[1] toggles low for 3 cycles then high, repeated 5 times, then held low -> no stable change during the toggling. A single capture bit 8'h02 is set 6 cycles after the final low level is held.
4. Interrupt and clear:
   - Write irqmask=8'h02 with bit 1 captured -> irq=1 the next cycle.
   - Write 8'h01 to address 2 -> irq remains 1.
   - Write 8'h02 to address 2 -> edgecapture=0 and irq=0 the next cycle.
5. Set-wins: write-1-to-clear bit 2 on the exact cycle its falling edge is captured -> edgecapture bit 2 reads 1 afterwards.
6. Polarity: write edgesel=8'h08, then pulse in_port[3] low for 10 cycles -> only the rising (release) edge sets bit 3. The falling edge is ignored. Bits 0 to 2 and 4 to 7 are unaffected.

Source files
------------

// File: rtl/button_pio_in.sv
// Avalon-MM input PIO for pushbuttons and switches.
// Each pin is synchronised, debounced and edge-detected. Selected edges are
// latched in sticky capture bits, which drive a maskable level interrupt.
module button_pio_in #(
  parameter int                 WIDTH           = 8,
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]   IN_RESET_VALUE  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Saturating increment keeps a debounce counter from ever wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edgesel;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic             wr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] detected;
  logic [WIDTH-1:0] clr;

  assign wr       = chipselect & ~write_n;
  assign rise     = stable & ~stable_d;
  assign fall     = ~stable & stable_d;
  assign detected = (edgesel & rise) | (~edgesel & fall);
  assign clr      = (wr && address == 2'd2) ? writedata : '0;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= IN_RESET_VALUE;
      sync2 <= IN_RESET_VALUE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept sync2 once it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= IN_RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= sat_inc(cnt[i]);
        end
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stable_d <= IN_RESET_VALUE;
    else       stable_d <= stable;
  end

  // Control registers; a newly detected edge wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask     <= '0;
      edgesel     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr && address == 2'd1) irqmask <= writedata;
      if (wr && address == 2'd3) edgesel <= writedata;
      edgecapture <= (edgecapture & ~clr) | detected;
    end
  end

  // Zero-wait-state read mux, driven low when not selected.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = stable;
        2'd1:    readdata = irqmask;
        2'd2:    readdata = edgecapture;
        default: readdata = edgesel;
      endcase
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_button_pio_in.sv
// Directed bench for button_pio_in with a short debounce window.
module tb_button_pio_in;

  logic       clk;
  logic       reset;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] in_port;
  logic [7:0] readdata;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  button_pio_in #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .IN_RESET_VALUE(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic compare_front(input logic [7:0] obs);
    logic [7:0] exp;
    string      tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    compare_front(readdata);
    chipselect = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    exp_q.push_back(8'h00);
    tag_q.push_back(tag);
    chipselect = 1'b0;
    address    = 2'd0;
    #1;
    compare_front(readdata);
  endtask

  task automatic expect_irq(input logic exp, input string tag);
    exp_q.push_back({7'b0, exp});
    tag_q.push_back(tag);
    #1;
    compare_front({7'b0, irq});
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_port    = 8'hFF;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 8'h00;

    // Reset, released and re-pulsed away from the clock edge
    repeat (2) @(negedge clk);
    expect_irq(1'b0, "irq_in_reset");
    #3 reset = 1'b0;
    expect_irq(1'b0, "irq_at_release");
    @(negedge clk);
    #4 reset = 1'b1;
    expect_irq(1'b0, "irq_in_pulse");
    #1 reset = 1'b0;
    @(negedge clk);
    expect_read(2'd0, 8'hFF, "rst_data");
    expect_read(2'd1, 8'h00, "rst_mask");
    expect_read(2'd2, 8'h00, "rst_cap");
    expect_read(2'd3, 8'h00, "rst_sel");
    expect_irq(1'b0, "rst_irq");

    // Latency: bit 0 falls before edge 0
    @(negedge clk);
    in_port = 8'hFE;
    repeat (5) @(negedge clk);
    expect_read(2'd0, 8'hFF, "lat_data_e4");
    @(negedge clk);
    expect_read(2'd0, 8'hFE, "lat_data_e5");
    expect_read(2'd2, 8'h00, "lat_cap_e5");
    @(negedge clk);
    expect_read(2'd2, 8'h01, "lat_cap_e6");
    expect_irq(1'b0, "lat_irq_masked");
    write_reg(2'd2, 8'h01);
    expect_read(2'd2, 8'h00, "w1c_bit0");

    // Bounce on bit 1: three low samples never qualify
    for (int r = 0; r < 5; r++) begin
      in_port = 8'hFC;
      repeat (3) @(negedge clk);
      in_port = 8'hFE;
      @(negedge clk);
      expect_read(2'd0, 8'hFE, "bounce_data");
      expect_read(2'd2, 8'h00, "bounce_cap");
    end
    in_port = 8'hFC;
    repeat (5) @(negedge clk);
    expect_read(2'd0, 8'hFE, "hold_data_e4");
    @(negedge clk);
    expect_read(2'd0, 8'hFC, "hold_data_e5");
    expect_read(2'd2, 8'h00, "hold_cap_e5");
    @(negedge clk);
    expect_read(2'd2, 8'h02, "hold_cap_e6");

    // Interrupt masking and write-1-to-clear
    expect_irq(1'b0, "mask0_irq");
    write_reg(2'd1, 8'h02);
    expect_irq(1'b1, "mask_irq");
    expect_read(2'd1, 8'h02, "mask_rd");
    write_reg(2'd2, 8'h01);
    expect_irq(1'b1, "w1c_other_irq");
    expect_read(2'd2, 8'h02, "w1c_other_cap");
    write_reg(2'd2, 8'h02);
    expect_read(2'd2, 8'h00, "w1c_clr_cap");
    expect_irq(1'b0, "w1c_clr_irq");
    write_reg(2'd0, 8'h00);
    expect_read(2'd0, 8'hFC, "data_read_only");
    expect_idle("idle_readdata");

    // Set wins over a same-cycle clear on bit 2
    in_port = 8'hF8;
    repeat (6) @(negedge clk);
    expect_read(2'd2, 8'h00, "sw_pre_cap");
    write_reg(2'd2, 8'h04);
    expect_read(2'd2, 8'h04, "set_wins");
    expect_irq(1'b0, "sw_irq_unmasked");
    write_reg(2'd2, 8'h04);
    expect_read(2'd2, 8'h00, "w1c_bit2");

    // Polarity: bit 3 captures only its rising edge
    write_reg(2'd3, 8'h08);
    expect_read(2'd3, 8'h08, "edgesel_rd");
    in_port = 8'hF0;
    repeat (10) @(negedge clk);
    expect_read(2'd2, 8'h00, "fall_ignored");
    expect_read(2'd0, 8'hF0, "pol_data_low");
    in_port = 8'hF8;
    repeat (6) @(negedge clk);
    expect_read(2'd2, 8'h00, "rise_cap_e5");
    @(negedge clk);
    expect_read(2'd2, 8'h08, "rise_cap_e6");
    expect_read(2'd0, 8'hF8, "pol_data_high");
    expect_irq(1'b0, "rise_irq_masked");
    write_reg(2'd1, 8'h08);
    expect_irq(1'b1, "rise_irq");

    // Asynchronous reset discards captured state immediately
    #2 reset = 1'b1;
    expect_irq(1'b0, "async_rst_irq");
    expect_read(2'd2, 8'h00, "async_rst_cap");
    expect_read(2'd0, 8'hFF, "async_rst_data");
    reset = 1'b0;
    @(negedge clk);
    expect_read(2'd1, 8'h00, "post_rst_mask");
    expect_read(2'd3, 8'h00, "post_rst_sel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
